ltpi_uart_sample_packer: RTL and testbench

Oversampling front end for the LTPI UART tunnel. It samples the local UART RX pin at a fixed divided rate and packs `SAMPLES` consecutive samples into one word. Words are buffered in a small FIFO, and one word is handed to the LTPI frame builder each time a frame slot requests the UART field. It sits directly upstream of the LTPI UART channel logic, which serialises `uart_field` into the outgoing frame.

---
 rtl/ltpi_uart_sample_packer.sv | 168 ++++++++++++++++
 tb/tb_ltpi_uart_sample_packer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ltpi_uart_sample_packer.sv
// UART RX oversampling front end for the LTPI tunnel: samples the pin at a divided rate,
// packs SAMPLES bits per word into a small FIFO. Optional macro: LTPI_UART_GLITCH_FILTER_EN.
module ltpi_uart_sample_packer #(
  parameter int unsigned SAMPLE_DIV = 16,
  parameter int unsigned SAMPLES    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               uart_rxd,
  input  logic               frame_req,
  input  logic               clear_status,
  output logic [SAMPLES-1:0] uart_field,
  output logic               field_valid,
  output logic               underrun,
  output logic               overflow
);
  localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
  localparam int unsigned PACK_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [PACK_W-1:0] PACK_LAST = PACK_W'(SAMPLES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  logic                sync1_q, sync2_q, sample_bit_s;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                strobe_s;
  logic [PACK_W-1:0]   pack_cnt_q, pack_cnt_d;
  logic [SAMPLES-1:0]  pack_q, pack_d;
  logic                push_s, pop_s, push_ok_s, drop_s, full_s, empty_s;
  logic [SAMPLES-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [SAMPLES-1:0]  field_q;
  logic                valid_q, underrun_q, overflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
    end
  end

`ifdef LTPI_UART_GLITCH_FILTER_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic tap0_q, tap1_q, filt_q;

  // Majority of the last three synchronised values; a 1-cycle glitch never wins the vote.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tap0_q <= 1'b1;
      tap1_q <= 1'b1;
      filt_q <= 1'b1;
    end else begin
      tap0_q <= sync2_q;
      tap1_q <= tap0_q;
      filt_q <= maj3(sync2_q, tap0_q, tap1_q);
    end
  end
  assign sample_bit_s = filt_q;
`else
  assign sample_bit_s = sync2_q;
`endif

  always_comb begin
    strobe_s   = (div_q == DIV_LAST);
    div_d      = strobe_s ? {DIV_W{1'b0}} : div_q + DIV_W'(1);
    pack_d     = pack_q;
    pack_cnt_d = pack_cnt_q;
    push_s     = 1'b0;
    if (strobe_s) begin
      pack_d[pack_cnt_q] = sample_bit_s;
      if (pack_cnt_q == PACK_LAST) begin
        push_s     = 1'b1;
        pack_cnt_d = {PACK_W{1'b0}};
      end else begin
        pack_cnt_d = pack_cnt_q + PACK_W'(1);
      end
    end else begin
      pack_d     = pack_q;
      pack_cnt_d = pack_cnt_q;
    end
  end

  // A pop frees the slot a simultaneous push needs, so full+pop+push never drops.
  always_comb begin
    full_s    = (count_q == CNT_FULL);
    empty_s   = (count_q == {CNT_W{1'b0}});
    pop_s     = frame_req && !empty_s;
    push_ok_s = push_s && (!full_s || pop_s);
    drop_s    = push_s && full_s && !pop_s;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= {DIV_W{1'b0}};
      pack_cnt_q <= {PACK_W{1'b0}};
      pack_q     <= {SAMPLES{1'b1}};
    end else begin
      div_q      <= div_d;
      pack_cnt_q <= pack_cnt_d;
      pack_q     <= pack_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= {SAMPLES{1'b1}};
      end
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= pack_d;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Status flags: a set event in the same cycle as clear_status wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      field_q    <= {SAMPLES{1'b1}};
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      valid_q <= frame_req;
      if (frame_req) begin
        field_q <= pop_s ? mem_q[rd_ptr_q] : {SAMPLES{1'b1}};
      end
      if (frame_req && empty_s) begin
        underrun_q <= 1'b1;
      end else if (clear_status) begin
        underrun_q <= 1'b0;
      end
      if (drop_s) begin
        overflow_q <= 1'b1;
      end else if (clear_status) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign uart_field  = field_q;
  assign field_valid = valid_q;
  assign underrun    = underrun_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ltpi_uart_sample_packer.sv
// Directed, table-driven bench for ltpi_uart_sample_packer (SAMPLE_DIV=4, SAMPLES=4, FIFO_DEPTH=4).
`timescale 1ns/1ps
module tb_ltpi_uart_sample_packer;
  logic       clk = 1'b0;
  logic       reset_n, uart_rxd, frame_req, clear_status;
  logic [3:0] uart_field;
  logic       field_valid, underrun, overflow;

  always #5 clk = ~clk;

  ltpi_uart_sample_packer #(.SAMPLE_DIV(4), .SAMPLES(4), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .uart_rxd    (uart_rxd),
    .frame_req   (frame_req),
    .clear_status(clear_status),
    .uart_field  (uart_field),
    .field_valid (field_valid),
    .underrun    (underrun),
    .overflow    (overflow)
  );

  typedef struct {
    int         tid;
    int         at_edge;
    logic       req;
    logic       clr;
    logic [3:0] f;
    logic       v;
    logic       u;
    logic       o;
  } vec_t;

  vec_t         vecs[$];
  int           n_run  = 0;
  int           n_fail = 0;
  int           edge_n = 0;
  logic [255:0] rx_pat;
  logic [255:0] p_ones, p2, p4, p6;

  function automatic void add(input int tid, input int e, input logic req, input logic clr,
                              input logic [3:0] f, input logic v, input logic u, input logic o);
    vec_t t;
    t.tid = tid; t.at_edge = e; t.req = req; t.clr = clr;
    t.f = f; t.v = v; t.u = u; t.o = o;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b, required %b", name, act, exp);
    end
  endtask

  // Sample s is taken at edge 4s; its pin value is driven after edge 4s-6 so it is stable
  // across the synchroniser (and filter) window.
  task automatic cyc();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    frame_req    = 1'b0;
    clear_status = 1'b0;
    if (edge_n % 4 == 2) uart_rxd = rx_pat[(edge_n + 2) / 4];
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) cyc();
  endtask

  task automatic do_reset(input logic [255:0] pat);
    reset_n      = 1'b0;
    frame_req    = 1'b0;
    clear_status = 1'b0;
    rx_pat       = pat;
    uart_rxd     = pat[0];
    #1;
    chk("rst_field",    uart_field, 4'b1111);
    chk("rst_valid",    {3'b000, field_valid}, 4'b0000);
    chk("rst_underrun", {3'b000, underrun}, 4'b0000);
    chk("rst_overflow", {3'b000, overflow}, 4'b0000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    edge_n  = 0;
  endtask

  task automatic run_tid(input int tid);
    foreach (vecs[i]) begin
      if (vecs[i].tid == tid) begin
        run_to(vecs[i].at_edge - 1);
        frame_req    = vecs[i].req;
        clear_status = vecs[i].clr;
        cyc();
        chk($sformatf("t%0d@%0d.valid", tid, vecs[i].at_edge), {3'b000, field_valid}, {3'b000, vecs[i].v});
        chk($sformatf("t%0d@%0d.underrun", tid, vecs[i].at_edge), {3'b000, underrun}, {3'b000, vecs[i].u});
        chk($sformatf("t%0d@%0d.overflow", tid, vecs[i].at_edge), {3'b000, overflow}, {3'b000, vecs[i].o});
        if (vecs[i].v) chk($sformatf("t%0d@%0d.field", tid, vecs[i].at_edge), uart_field, vecs[i].f);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; uart_rxd = 1'b1; frame_req = 1'b0; clear_status = 1'b0;
    p_ones = '1;
    p2 = '1; p2[15:0] = {4'b1100, 4'b0001, 4'b0110, 4'b1111};
    p4 = '1; p4[19:0] = {4'b0111, 4'b1110, 4'b1001, 4'b0011, 4'b0101};
    p6 = '1; p6[3:0] = 4'b0101; p6[21:20] = 2'b00;

    // 1: idle pin, four words of ones
    add(1, 60, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    add(1, 65, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    add(1, 66, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    add(1, 67, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    add(1, 68, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    add(1, 69, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    // 2: sample patterns, bit 0 oldest
    add(2, 17, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    add(2, 18, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    add(2, 33, 1'b1, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0);
    add(2, 34, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    add(2, 49, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
    add(2, 65, 1'b1, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0);
    // 3: underrun, clear, set-wins, empty push+pop, back-to-back pops
    add(3,  1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);
    add(3,  2, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    add(3,  3, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    add(3,  5, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0);
    add(3,  7, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    add(3, 16, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);
    add(3, 17, 1'b1, 1'b0, 4'b0101, 1'b1, 1'b1, 1'b0);
    add(3, 18, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);
    // 4: overflow on the fifth word, oldest data kept
    add(4, 79, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    add(4, 80, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(4, 81, 1'b1, 1'b0, 4'b0101, 1'b1, 1'b0, 1'b1);
    add(4, 82, 1'b1, 1'b0, 4'b0011, 1'b1, 1'b0, 1'b1);
    add(4, 83, 1'b1, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b1);
    add(4, 84, 1'b1, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b1);
    add(4, 85, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b1);
    add(4, 86, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    // 5: pop in the same cycle as the push into a full FIFO
    add(5, 80, 1'b1, 1'b0, 4'b0101, 1'b1, 1'b0, 1'b0);
    add(5, 81, 1'b1, 1'b0, 4'b0011, 1'b1, 1'b0, 1'b0);
    add(5, 82, 1'b1, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0);
    add(5, 83, 1'b1, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0);
    add(5, 84, 1'b1, 1'b0, 4'b0111, 1'b1, 1'b0, 1'b0);
    add(5, 85, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    do_reset(p_ones); run_tid(1);
    do_reset(p2);     run_tid(2);
    do_reset(p4);     run_tid(3);
    do_reset(p4);     run_tid(4);
    do_reset(p4);     run_tid(5);

    // 6: reset in the middle of a word with a full FIFO and overflow pending
    do_reset(p6);
    run_to(80);
    chk("t6.pre_overflow", {3'b000, overflow}, 4'b0001);
    run_to(87);
    frame_req = 1'b1;
    cyc();
    chk("t6.pre_field", uart_field, 4'b0101);
    chk("t6.pre_valid", {3'b000, field_valid}, 4'b0001);
    do_reset(p4);
    run_to(11);
    frame_req = 1'b1;
    cyc();
    chk("t6.post_empty_field", uart_field, 4'b1111);
    chk("t6.post_empty_underrun", {3'b000, underrun}, 4'b0001);
    run_to(16);
    frame_req = 1'b1;
    cyc();
    chk("t6.post_word1", uart_field, 4'b0101);
    chk("t6.post_word1_valid", {3'b000, field_valid}, 4'b0001);

`ifdef LTPI_UART_GLITCH_FILTER_EN
    do_reset(p_ones);
    run_to(7);
    uart_rxd = 1'b0;
    cyc();
    uart_rxd = 1'b1;
    run_to(16);
    frame_req = 1'b1;
    cyc();
    chk("glitch.field", uart_field, 4'b1111);
    chk("glitch.underrun", {3'b000, underrun}, 4'b0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
